ps2_mouse_packet: RTL and testbench

PS2_MOUSE_PACKET -- requirements
Module: ps2_mouse_packet

---
 rtl/ps2_mouse_packet.sv | 168 ++++++++++++++++
 tb/tb_ps2_mouse_packet.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse receiver: synchronises and deglitches the PS/2 lines, frames
// 11-bit serial bytes and assembles 3-byte movement packets into decoded outputs.
module ps2_mouse_packet #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 6000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       ps2_mouse_clk,
  input  logic       ps2_mouse_data,
  output logic       pkt_valid,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       err,
  output logic [1:0] frame_state
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

  state_t        state;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic          fall;
  logic          abort;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [1:0]    idx;
  logic [6:0]    hdr;   // byte 0 without its always-one sync bit: {b7,b6,b5,b4,b2,b1,b0}
  logic [7:0]    byte1;

  assign frame_state = state;

  function automatic logic [8:0] sat_move(input logic ovf, input logic sign,
                                          input logic [7:0] mag);
    if (ovf) return sign ? 9'h100 : 9'h0FF;
    return {sign, mag};
  endfunction

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_mouse_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_mouse_data;
      dat_s2 <= dat_s1;
    end
  end

  // The filter counts consecutive ce samples that disagree with the current level.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (ce) begin
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = ce && filt_clk && !clk_s2 && (filt_cnt == FILT_MAX);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (fall) begin
      to_cnt <= '0;
    end else if (ce && to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign abort = (to_cnt == TO_MAX) && ((state != IDLE) || (idx != 2'd0));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_ok    <= 1'b0;
      idx       <= '0;
      hdr       <= '0;
      byte1     <= '0;
      pkt_valid <= 1'b0;
      err       <= 1'b0;
      buttons   <= '0;
      dx        <= '0;
      dy        <= '0;
    end else begin
      pkt_valid <= 1'b0;
      err       <= 1'b0;
      if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shreg, dat_s2};
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat_s2 || !par_ok) begin
              err <= 1'b1;
              idx <= 2'd0;
            end else begin
              case (idx)
                2'd0: begin
                  // Bit 3 of the header is always set; a clear bit means we lost sync.
                  if (!shreg[3]) begin
                    err <= 1'b1;
                  end else begin
                    hdr <= {shreg[7:4], shreg[2:0]};
                    idx <= 2'd1;
                  end
                end
                2'd1: begin
                  byte1 <= shreg;
                  idx   <= 2'd2;
                end
                2'd2: begin
                  idx       <= 2'd0;
                  pkt_valid <= 1'b1;
                  buttons   <= hdr[2:0];
                  dx        <= sat_move(hdr[5], hdr[3], byte1);
                  dy        <= sat_move(hdr[6], hdr[4], shreg);
                end
                default: idx <= 2'd0;
              endcase
            end
          end
          default: state <= IDLE;
        endcase
      end else if (abort) begin
        state <= IDLE;
        idx   <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Bench for ps2_mouse_packet: serialises PS/2 frames at a slow line rate and
// checks decoded packets, error pulses, timeout, glitch rejection and reset.
module tb_ps2_mouse_packet;

  localparam int FILT_LEN = 8;
  localparam int TIMEOUT  = 200;
  localparam int CE_DIV   = 8;
  localparam int HALF     = 88;
  localparam int GLITCH   = (FILT_LEN - 1) * CE_DIV;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       ps2_mouse_clk;
  logic       ps2_mouse_data;
  logic       pkt_valid;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       err;
  logic [1:0] frame_state;

  ps2_mouse_packet #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .ce             (ce),
    .ps2_mouse_clk  (ps2_mouse_clk),
    .ps2_mouse_data (ps2_mouse_data),
    .pkt_valid      (pkt_valid),
    .buttons        (buttons),
    .dx             (dx),
    .dy             (dy),
    .err            (err),
    .frame_state    (frame_state)
  );

  // ---------------- clock / reset / ce ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    int div;
    div = 0;
    ce  = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      ce  = (div == CE_DIV - 1);
      div = (div + 1) % CE_DIV;
    end
  end

  // ---------------- monitor ----------------
  int          pkt_cnt  = 0;
  int          err_cnt  = 0;
  int          both_cnt = 0;
  logic [20:0] cap      = '0;

  always @(negedge clk_sys) begin
    if (pkt_valid) begin
      pkt_cnt = pkt_cnt + 1;
      cap     = {buttons, dx, dy};
    end
    if (err) err_cnt = err_cnt + 1;
    if (pkt_valid && err) both_cnt = both_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [20:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic ps2_bit(input logic b, input logic glitch);
    ps2_mouse_data = b;
    tick(HALF);
    if (glitch) begin
      ps2_mouse_clk = 1'b0;
      tick(GLITCH);
      ps2_mouse_clk = 1'b1;
      tick(HALF);
    end
    ps2_mouse_clk = 1'b0;
    tick(HALF);
    ps2_mouse_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input int glitch_bit);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(frame[i], glitch_bit == i);
    ps2_mouse_data = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0, -1);
    send_byte(b1, 1'b0, -1);
    send_byte(b2, 1'b0, -1);
  endtask

  // Waits (bounded) for the expected pulse, then compares against the queue head.
  task automatic check_pkt(input string name, input int p0);
    logic [20:0] exp;
    int budget;
    budget = 300;
    while (pkt_cnt == p0 && budget > 0) begin
      tick(1);
      budget--;
    end
    tick(20);
    check({name, "_pulses"}, pkt_cnt - p0, 1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 21'h0;
    check({name, "_data"}, cap, exp);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [2:0] btn;
    logic [8:0] ex, ey;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int p0, e0;
    logic [20:0] held;

    vecs[0] = '{b0: 8'h08, b1: 8'h05, b2: 8'hFB, btn: 3'b000, ex: 9'h005, ey: 9'h0FB};
    vecs[1] = '{b0: 8'h28, b1: 8'h05, b2: 8'hFB, btn: 3'b000, ex: 9'h005, ey: 9'h1FB};
    vecs[2] = '{b0: 8'h59, b1: 8'h02, b2: 8'h03, btn: 3'b001, ex: 9'h100, ey: 9'h003};
    vecs[3] = '{b0: 8'hD9, b1: 8'h02, b2: 8'h03, btn: 3'b001, ex: 9'h100, ey: 9'h0FF};

    rst_n          = 1'b0;
    ps2_mouse_clk  = 1'b1;
    ps2_mouse_data = 1'b1;
    tick(5);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_err", err, 0);
    check("rst_outputs", {buttons, dx, dy}, 0);
    check("rst_state", frame_state, 0);
    rst_n = 1'b1;
    tick(2 * HALF);

    for (int i = 0; i < 4; i++) begin
      p0 = pkt_cnt;
      e0 = err_cnt;
      exp_q.push_back({vecs[i].btn, vecs[i].ex, vecs[i].ey});
      send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      check_pkt($sformatf("vec%0d", i), p0);
      check($sformatf("vec%0d_err", i), err_cnt - e0, 0);
    end

    // Bad parity on a header byte: error, nothing emitted, outputs held.
    held = {buttons, dx, dy};
    p0 = pkt_cnt;
    e0 = err_cnt;
    send_byte(8'h08, 1'b1, -1);
    check("parity_err", err_cnt - e0, 1);
    check("parity_no_pkt", pkt_cnt - p0, 0);
    check("parity_hold", {buttons, dx, dy}, held);
    exp_q.push_back({3'b010, 9'h010, 9'h020});
    send_pkt(8'h0A, 8'h10, 8'h20);
    check_pkt("after_parity", p0);
    check("after_parity_err", err_cnt - e0, 1);

    // Header without sync bit: resync error, index stays at byte 0.
    p0 = pkt_cnt;
    e0 = err_cnt;
    send_byte(8'h00, 1'b0, -1);
    check("sync_err", err_cnt - e0, 1);
    check("sync_no_pkt", pkt_cnt - p0, 0);
    exp_q.push_back({3'b001, 9'h001, 9'h001});
    send_pkt(8'h09, 8'h01, 8'h01);
    check_pkt("after_sync", p0);

    // Two bytes then silence: packet abandoned quietly.
    p0 = pkt_cnt;
    e0 = err_cnt;
    send_byte(8'h1B, 1'b0, -1);
    send_byte(8'h7F, 1'b0, -1);
    tick((TIMEOUT + 10) * CE_DIV);
    check("timeout_no_err", err_cnt - e0, 0);
    check("timeout_no_pkt", pkt_cnt - p0, 0);
    check("timeout_state", frame_state, 0);
    exp_q.push_back({3'b100, 9'h0FF, 9'h080});
    send_pkt(8'h0C, 8'hFF, 8'h80);
    check_pkt("after_timeout", p0);

    // Short low glitch on the clock in the middle of byte 1.
    p0 = pkt_cnt;
    e0 = err_cnt;
    exp_q.push_back({3'b100, 9'h181, 9'h17E});
    send_byte(8'h3C, 1'b0, -1);
    send_byte(8'h81, 1'b0, 4);
    send_byte(8'h7E, 1'b0, -1);
    check_pkt("glitch", p0);
    check("glitch_err", err_cnt - e0, 0);

    // Reset in the middle of a byte.
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
    rst_n = 1'b0;
    tick(3);
    check("midrst_outputs", {buttons, dx, dy}, 0);
    check("midrst_state", frame_state, 0);
    check("midrst_flags", {pkt_valid, err}, 0);
    rst_n = 1'b1;
    ps2_mouse_data = 1'b1;
    tick(2 * HALF);
    p0 = pkt_cnt;
    e0 = err_cnt;
    exp_q.push_back({3'b111, 9'h040, 9'h1C0});
    send_pkt(8'h2F, 8'h40, 8'hC0);
    check_pkt("after_reset", p0);
    check("after_reset_err", err_cnt - e0, 0);

    check("valid_err_overlap", both_cnt, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
